// File: rtl/io_cond_pkg.sv
// rtl/io_cond_pkg.sv - shared defaults and debounce state type for io_input_cond
package io_cond_pkg;

  localparam int SW_W_DEF         = 32;
  localparam int BTN_W_DEF        = 4;
  localparam int SYNC_STAGES_DEF  = 2;
  localparam int TICK_CYCLES_DEF  = 50000;
  localparam int STABLE_TICKS_DEF = 10;

  localparam int TICK_CNT_W = $clog2(TICK_CYCLES_DEF);

  typedef struct packed {
    logic       stable;
    logic [3:0] cnt;
  } debounce_state_t;

endpackage

// File: rtl/io_debounce_cell.sv
// rtl/io_debounce_cell.sv - one input: synchroniser, tick-counted debounce, stable flop
module io_debounce_cell
  import io_cond_pkg::*;
#(
  parameter int SYNC_STAGES  = SYNC_STAGES_DEF,
  parameter int STABLE_TICKS = STABLE_TICKS_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  input  logic i_tick,
  output logic o_stable
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  debounce_state_t        st;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], i_raw};
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // Any matching sample discards accumulated progress, so short bounce never lands.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      st <= '0;
    end else if (synced == st.stable) begin
      st.cnt <= '0;
    end else if (i_tick) begin
      if (st.cnt == 4'(STABLE_TICKS - 1)) begin
        st.stable <= synced;
        st.cnt    <= '0;
      end else begin
        st.cnt <= st.cnt + 4'd1;
      end
    end
  end

  assign o_stable = st.stable;

endmodule

// File: rtl/io_input_cond.sv
// rtl/io_input_cond.sv - switch/button conditioning for LSU MMIO; events gated by IO_COND_EVENT_EN
module io_input_cond
  import io_cond_pkg::*;
#(
  parameter int SW_W         = SW_W_DEF,
  parameter int BTN_W        = BTN_W_DEF,
  parameter int SYNC_STAGES  = SYNC_STAGES_DEF,
  parameter int TICK_CYCLES  = TICK_CYCLES_DEF,
  parameter int STABLE_TICKS = STABLE_TICKS_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [SW_W-1:0]  i_sw_raw,
  input  logic [BTN_W-1:0] i_btn_raw,
  output logic [SW_W-1:0]  o_io_sw,
  output logic [BTN_W-1:0] o_io_btn,
  output logic [BTN_W-1:0] o_btn_press,
  output logic             o_sw_chg
);

  localparam int CELLS = SW_W + BTN_W;
  localparam int CW    = (TICK_CYCLES == TICK_CYCLES_DEF) ? TICK_CNT_W : $clog2(TICK_CYCLES);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("io_input_cond: SYNC_STAGES must be >= 2");
  end
  if (TICK_CYCLES < 2) begin : g_bad_tick
    $error("io_input_cond: TICK_CYCLES must be >= 2");
  end
  if (STABLE_TICKS < 1 || STABLE_TICKS > 15) begin : g_bad_stable
    $error("io_input_cond: STABLE_TICKS must be in 1..15");
  end

  logic [CW-1:0]    presc;
  logic             tick;
  logic [CELLS-1:0] raw;
  logic [CELLS-1:0] stable;

  assign tick = (presc == CW'(TICK_CYCLES - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)     presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + CW'(1);
  end

  // Buttons are active-low on the board; flip them once so every cell is active-high.
  assign raw = {~i_btn_raw, i_sw_raw};

  for (genvar g = 0; g < CELLS; g++) begin : g_cell
    io_debounce_cell #(
      .SYNC_STAGES (SYNC_STAGES),
      .STABLE_TICKS(STABLE_TICKS)
    ) u_cell (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_raw   (raw[g]),
      .i_tick  (tick),
      .o_stable(stable[g])
    );
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_io_sw  <= '0;
      o_io_btn <= '0;
    end else begin
      o_io_sw  <= stable[SW_W-1:0];
      o_io_btn <= stable[CELLS-1:SW_W];
    end
  end

`ifdef IO_COND_EVENT_EN
  // Outputs still hold the previous level, so the pulse lines up with the new one.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_btn_press <= '0;
      o_sw_chg    <= 1'b0;
    end else begin
      o_btn_press <= stable[CELLS-1:SW_W] & ~o_io_btn;
      o_sw_chg    <= |(stable[SW_W-1:0] ^ o_io_sw);
    end
  end
`else
  assign o_btn_press = '0;
  assign o_sw_chg    = 1'b0;
`endif

endmodule
